// File: rtl/output_collector.sv
// Receive-side collector: writes streamed result words to the output buffer at
// linearly increasing addresses, grouping them into tiles and reporting job status.
module output_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int TILING_SIZE = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter bit RELU_EN     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           num_tiles,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           tile_count,
    output logic                  overrun
);

    localparam int IDX_W = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILING_SIZE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_r;
    logic [1:0]            next_state_s;
    logic [15:0]           exp_tiles_r;
    logic [ADDR_WIDTH-1:0] addr_cnt_r;
    logic [IDX_W-1:0]      word_idx_r;
    logic                  start_ok_s;
    logic                  accept_s;
    logic                  tile_end_s;

    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  busy_r;
    logic                  done_r;
    logic [15:0]           tile_count_r;
    logic                  overrun_r;

    // Negative words are clamped to zero when ReLU is enabled.
    function automatic logic [DATA_WIDTH-1:0] relu_clamp(input logic [DATA_WIDTH-1:0] d);
        if (RELU_EN && d[DATA_WIDTH-1]) begin
            return {DATA_WIDTH{1'b0}};
        end else begin
            return d;
        end
    endfunction

    // Next-state decode and per-cycle accept/tile-boundary qualifiers.
    always_comb begin
        next_state_s = state_r;
        start_ok_s   = 1'b0;
        accept_s     = 1'b0;
        tile_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    if (num_tiles != 16'd0) begin
                        next_state_s = ST_RECV;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (word_idx_r == LAST_IDX) begin
                        tile_end_s = 1'b1;
                        if ((tile_count_r + 16'd1) == exp_tiles_r) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_RECV;
                        end
                    end else begin
                        next_state_s = ST_RECV;
                    end
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            exp_tiles_r  <= 16'd0;
            addr_cnt_r   <= {ADDR_WIDTH{1'b0}};
            word_idx_r   <= {IDX_W{1'b0}};
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            tile_count_r <= 16'd0;
            overrun_r    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            // busy stays up through the final write and drops together with done rising
            busy_r   <= (next_state_s == ST_RECV) || (state_r == ST_RECV);
            done_r   <= (state_r == ST_DONE);
            mem_we_r <= accept_s;
            if (start_ok_s) begin
                exp_tiles_r  <= num_tiles;
                addr_cnt_r   <= base_addr;
                word_idx_r   <= {IDX_W{1'b0}};
                tile_count_r <= 16'd0;
                overrun_r    <= in_valid;
            end else if (accept_s) begin
                mem_addr_r  <= addr_cnt_r;
                mem_wdata_r <= relu_clamp(in_data);
                addr_cnt_r  <= addr_cnt_r + ADDR_WIDTH'(1'b1);
                if (tile_end_s) begin
                    word_idx_r   <= {IDX_W{1'b0}};
                    tile_count_r <= tile_count_r + 16'd1;
                end else begin
                    word_idx_r <= word_idx_r + IDX_W'(1'b1);
                end
            end else if (in_valid && (state_r != ST_RECV)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign tile_count = tile_count_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_output_collector.sv
// Self-checking bench for output_collector: directed scenarios plus randomized jobs,
// compared every cycle against a word-counting reference model.
module tb_output_collector;

    localparam int DW = 16;
    localparam int TS = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_tiles = 16'd0;
    logic [AW-1:0] base_addr = 16'd0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = 16'd0;

    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1;
    logic          busy0, busy1, done0, done1, ovr0, ovr1;
    logic [15:0]   tc0, tc1;

    int total = 0;
    int bad   = 0;

    // Reference model: job phase (0 idle, 1 receiving, 2 done), words written, words expected
    int            m_phase = 0;
    int            m_written = 0;
    int            m_total = 0;
    logic [AW-1:0] m_addr = 16'd0;
    logic          e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ovr = 1'b0;
    logic [AW-1:0] e_addr = 16'd0;
    logic [DW-1:0] e_d0 = 16'd0, e_d1 = 16'd0;
    logic [15:0]   e_tc = 16'd0;

    always #5 clk = ~clk;

    output_collector #(.DATA_WIDTH(DW), .TILING_SIZE(TS), .ADDR_WIDTH(AW), .RELU_EN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .busy(busy0), .done(done0), .tile_count(tc0), .overrun(ovr0)
    );

    output_collector #(.DATA_WIDTH(DW), .TILING_SIZE(TS), .ADDR_WIDTH(AW), .RELU_EN(1'b1)) u_dut_relu (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .busy(busy1), .done(done1), .tile_count(tc1), .overrun(ovr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int old_phase;
        old_phase = m_phase;
        e_we = 1'b0;
        if (rst) begin
            m_phase = 0; m_written = 0; m_total = 0; m_addr = 16'd0;
            e_addr = 16'd0; e_d0 = 16'd0; e_d1 = 16'd0;
            e_ovr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_tc = 16'd0;
        end else begin
            e_done = (m_phase == 2);
            case (m_phase)
                0: begin
                    if (start) begin
                        e_ovr     = in_valid;
                        m_written = 0;
                        m_total   = int'(num_tiles) * TS;
                        m_addr    = base_addr;
                        m_phase   = (num_tiles != 16'd0) ? 1 : 2;
                    end else if (in_valid) begin
                        e_ovr = 1'b1;
                    end
                end
                1: begin
                    if (in_valid) begin
                        e_we   = 1'b1;
                        e_addr = m_addr;
                        e_d0   = in_data;
                        e_d1   = in_data[DW-1] ? 16'd0 : in_data;
                        m_addr = m_addr + 16'd1;
                        m_written++;
                        if (m_written == m_total) m_phase = 2;
                    end
                end
                default: begin
                    if (in_valid) e_ovr = 1'b1;
                    m_phase = 0;
                end
            endcase
            e_busy = (m_phase == 1) || (old_phase == 1);
            e_tc   = 16'(m_written / TS);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("mem_we",         32'(we0),   32'(e_we));
        chk("mem_we_relu",    32'(we1),   32'(e_we));
        chk("mem_addr",       32'(addr0), 32'(e_addr));
        chk("mem_addr_relu",  32'(addr1), 32'(e_addr));
        chk("mem_wdata",      32'(wd0),   32'(e_d0));
        chk("mem_wdata_relu", 32'(wd1),   32'(e_d1));
        chk("busy",           32'(busy0), 32'(e_busy));
        chk("done",           32'(done0), 32'(e_done));
        chk("done_relu",      32'(done1), 32'(e_done));
        chk("tile_count",     32'(tc0),   32'(e_tc));
        chk("overrun",        32'(ovr0),  32'(e_ovr));
        chk("overrun_relu",   32'(ovr1),  32'(e_ovr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_start(input logic [15:0] nt, input logic [AW-1:0] base);
        start = 1'b1; num_tiles = nt; base_addr = base;
        cycle();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        in_valid = 1'b1; in_data = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] relu_words [8];
        int nt;
        relu_words = '{16'hFFFB, 16'd7, 16'h8000, 16'd0, 16'd1, 16'hFFFF, 16'd100, 16'hFF9C};

        // reset
        idle(2);
        rst = 1'b0;
        idle(1);

        // basic two-tile job, words 1..16 back to back
        do_start(16'd2, 16'h0100);
        for (int i = 1; i <= 16; i++) send_word(16'(i));
        idle(3);

        // gapped single tile
        do_start(16'd1, 16'h0200);
        for (int i = 0; i < 8; i++) begin
            send_word(16'(16'h0A0 + i));
            idle(1);
        end
        idle(2);

        // ReLU pattern on both instances
        do_start(16'd1, 16'h0300);
        for (int i = 0; i < 8; i++) send_word(relu_words[i]);
        idle(3);

        // zero-tile job, then overrun while idle, then a start clears it
        do_start(16'd0, 16'h0400);
        idle(3);
        send_word(16'h1234);
        idle(2);

        // reset after the fifth word, then a fresh job
        do_start(16'd1, 16'h0500);
        for (int i = 0; i < 5; i++) send_word(16'(16'h050 + i));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        do_start(16'd1, 16'h0600);
        for (int i = 0; i < 8; i++) send_word(16'(16'h060 + i));
        idle(2);

        // address wrap, then a second start right as done is high
        do_start(16'd1, 16'hFFFC);
        for (int i = 0; i < 8; i++) send_word(16'(16'h070 + i));
        idle(1);
        do_start(16'd1, 16'h0010);
        for (int i = 0; i < 8; i++) send_word(16'(16'h080 + i));
        idle(3);

        // randomized jobs with gaps, ignored starts and trailing overrun words
        for (int j = 0; j < 30; j++) begin
            nt = int'($urandom_range(0, 3));
            do_start(16'(nt), 16'($urandom));
            for (int w = 0; w < nt * TS; w++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if (w > 0 && $urandom_range(0, 7) == 0) begin
                    start = 1'b1;
                    num_tiles = 16'($urandom_range(1, 5));
                    base_addr = 16'($urandom);
                end
                send_word(16'($urandom));
                start = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) send_word(16'($urandom));
            idle(int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_collector.md
# output_collector

Receive-side counterpart of the tile output streamer. It accepts the serialized result words that the streamer emits one per cycle under a valid strobe, and groups them into tiles of TILING_SIZE words. Each word is written to the output buffer at a linearly increasing address, with optional ReLU clamping. It reports per-job progress, completion and overrun to the top-level controller.

## Interface
- DATA_WIDTH, 16, width of each result word (signed two's complement)
- TILING_SIZE, 8, words per tile; must be ≥ 1
- ADDR_WIDTH, 16, output buffer address width
- RELU_EN, 0, 1 = negative words are written as 0
- clk  input  1  single clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse; latches num_tiles and base_addr when IDLE
- num_tiles  input  16  tiles expected in this job
- base_addr  input  ADDR_WIDTH  address of first word
- in_valid  input  1  word present on in_data this cycle
- in_data  input  DATA_WIDTH  result word from streamer
- mem_we  output  1  output buffer write enable
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  DATA_WIDTH  write data
- busy  output  1  high in RECV
- done  output  1  one-cycle completion pulse
- tile_count  output  16  tiles fully written in current or last job
- overrun  output  1  sticky: a word arrived while not in RECV

## Operation
- Reset value of every output is 0: mem_we, mem_addr, mem_wdata, busy, done, tile_count, overrun. Internal state returns to IDLE, and word_idx and the address counter clear.
- State IDLE:
  - start with num_tiles ≠ 0 → RECV. Latches exp_tiles = num_tiles and addr_cnt = base_addr. Clears word_idx, tile_count and overrun.
  - start with num_tiles = 0 → DONE. No writes occur; tile_count and overrun are cleared.
- State RECV:
  - Each cycle with in_valid = 1 is accepted.
  - An accepted word produces one write: mem_addr = addr_cnt, and mem_wdata = in_data, or 0 if RELU_EN = 1 and in_data is negative.
  - After the write, addr_cnt increments modulo 2^ADDR_WIDTH and word_idx increments.
  - When word_idx reaches TILING_SIZE−1 on an accepted word: word_idx clears and tile_count increments.
  - If that tile_count increment reaches exp_tiles → DONE.
  - Gaps are legal: in_valid may drop mid-tile; word_idx and addr_cnt hold until in_valid returns.
- State DONE: lasts exactly one cycle, then unconditionally → IDLE.
- Overrun: in_valid = 1 in IDLE or DONE sets overrun. The word is dropped and no write occurs. overrun clears only on an accepted start or on rst.
- start while in RECV or DONE is ignored, and num_tiles/base_addr are not re-latched.
- Back-to-back jobs: start may arrive on the cycle immediately after done. That start is seen in IDLE and is accepted.
- tile_count holds its final value after DONE until the next accepted start.

## Timing
- Write latency is 1 cycle. For in_valid sampled at edge N, mem_we/mem_addr/mem_wdata are registered at edge N and are valid during cycle N+1.
- mem_we is high for exactly one cycle per accepted word. mem_addr and mem_wdata hold their last value when mem_we is low.
- Job start to first accept:
  - start sampled at edge S; busy is high from S+1.
  - The earliest accepted word is the in_valid sampled at edge S+1.
- Completion:
  - The last word is sampled at edge L, where the state moves to DONE and the final mem_we registers.
  - done is registered at edge L+1 and is high for the cycle after the final mem_we. busy falls in that same cycle.
- Throughput: 1 word/cycle sustained, no backpressure. The source must not exceed num_tiles·TILING_SIZE words per job; any excess words are counted as overrun.
- rst mid-job: at the next edge all outputs are 0 and the state is IDLE. No write is issued in the cycle after rst, and the partial tile is discarded.
- The address counter wraps silently from 2^ADDR_WIDTH−1 to 0.

## Test plan
- Basic job: TILING_SIZE=8, start with num_tiles=2 and base_addr=0x0100, then 16 consecutive words 1..16.
  - Required: writes at 0x0100..0x010F with data 1..16, each mem_we one cycle after its in_valid.
  - done pulses once, one cycle after the last write; tile_count = 2.
- Gapped stream: 1 tile with in_valid toggling 1,0,1,0…
  - Required: 8 writes at contiguous addresses with no skipped address.
  - tile_count goes 0→1 only after the 8th word.
- ReLU: RELU_EN=1, words −5, 7, −32768, 0.
  - Required: written data is 0, 7, 0, 0.
  - With RELU_EN=0 the written data equals the input words unchanged.
- Zero-tile job and overrun:
  - start with num_tiles=0 → done exactly 2 cycles after start is sampled, no mem_we.
  - A subsequent in_valid while IDLE sets overrun = 1 with no write; the next accepted start clears overrun.
- Reset mid-job: rst asserted after the 5th word of a 1-tile job.
  - Required: all outputs 0 on the next cycle and no further writes.
  - A fresh job then writes from its new base_addr with tile_count starting at 0.
- Wrap and back-to-back: base_addr=0xFFFC, num_tiles=1, then a second start in the cycle right after done.
  - Required: first-job addresses FFFC..FFFF, 0000..0003.
  - The second job is accepted and busy rises the next cycle.
